// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding and oversampling constants.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE       = 16;
    localparam int MID_SAMPLE       = 8;
    localparam int TICK_DIV_DEFAULT = 326;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        , ST_PARITY  = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received payload and status out. parity_err appears only with UART_RX_PARITY_EN.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport slave  (input rx, output data, output valid, output frame_err, output busy, output parity_err);
    modport master (output rx, input data, input valid, input frame_err, input busy, input parity_err);
`else
    modport slave  (input rx, output data, output valid, output frame_err, output busy);
    modport master (output rx, input data, input valid, input frame_err, input busy);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick generator; i_clr realigns the phase to a start edge.
module uart_baud_tick #(
    parameter int TICK_DIV = 326
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, LSB first, 8N1 by default.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DATA_BITS = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] MID_LAST  = SW'(MID_SAMPLE - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [SW-1:0]        r_scnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    logic w_rx;
    logic w_tick;
    logic w_mid;
    logic w_full;
    logic w_busy;
    logic w_start_det;
    logic w_scnt_clr;
    logic w_shift_en;
    logic w_stop_ok;
    logic w_stop_bad;
    logic w_par_bad;

    assign w_rx   = r_sync2;
    assign w_mid  = w_tick && (r_scnt == MID_LAST);
    assign w_full = w_tick && (r_scnt == FULL_LAST);

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_start_det),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (!w_rx) w_next = ST_START;
            ST_START:     if (w_mid) w_next = w_rx ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:      if (w_full && r_bit == BIT_LAST) w_next = ST_PARITY;
            ST_PARITY:    if (w_full) w_next = ST_STOP;
`else
            ST_DATA:      if (w_full && r_bit == BIT_LAST) w_next = ST_STOP;
`endif
            ST_STOP:      if (w_full) w_next = w_rx ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (w_rx) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_start_det = (r_state == ST_IDLE) && !w_rx;
        w_scnt_clr  = (r_state == ST_IDLE) || ((r_state == ST_START) && w_mid) || w_full;
        w_shift_en  = (r_state == ST_DATA) && w_full;
        w_stop_ok   = (r_state == ST_STOP) && w_full && w_rx;
        w_stop_bad  = (r_state == ST_STOP) && w_full && !w_rx;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_perr;

    // Even parity: payload ones plus the parity bit must total an even count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if ((r_state == ST_PARITY) && w_full) r_par_bad <= w_rx ^ (^r_shift);
            r_perr <= (w_stop_ok || w_stop_bad) && r_par_bad;
        end
    end

    assign w_par_bad      = r_par_bad;
    assign bus.parity_err = r_perr;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_scnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;

            if (w_scnt_clr) r_scnt <= '0;
            else if (w_tick) r_scnt <= r_scnt + 1'b1;

            if (r_state != ST_DATA) r_bit <= '0;
            else if (w_shift_en) r_bit <= r_bit + 1'b1;

            if (w_shift_en) r_shift[r_bit] <= w_rx;

            // A bad stop bit leaves data untouched; frame_err and valid are mutually exclusive.
            r_valid <= w_stop_ok && !w_par_bad;
            r_ferr  <= w_stop_bad;
            if (w_stop_ok && !w_par_bad) r_data <= r_shift;
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at TICK_DIV=4 (one bit = 64 clk); covers the parity build when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    localparam int TD  = 4;
    localparam int BIT = 16 * TD;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = (8 + 16 * 10) * TD;
`else
    localparam int LAT = (8 + 16 * 9) * TD;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.TICK_DIV(TD), .DATA_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts, captured data, width/overlap violations, start-to-valid latency.
    int         cyc = 0, t_busy = 0, lat = 0;
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0, n_wide = 0;
    logic       prev_v = 1'b0, prev_f = 1'b0, prev_b = 1'b0;
    logic [7:0] dq[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.valid && bus.frame_err) n_both++;
        if ((bus.valid && prev_v) || (bus.frame_err && prev_f)) n_wide++;
        if (bus.valid) begin
            n_valid++;
            dq.push_back(bus.data);
            lat = cyc - t_busy;
        end
        if (bus.frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) n_perr++;
`endif
        if (bus.busy && !prev_b) t_busy = cyc;
        prev_v = bus.valid;
        prev_f = bus.frame_err;
        prev_b = bus.busy;
    end

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_p(input logic [7:0] d, input logic pbit, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold(pbit, BIT);
`else
        if (pbit === 1'bx) hold(1'b1, 1);
`endif
        hold(stop, BIT);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        send_p(d, ^d, stop);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nv, nf, i0, dur;
        logic [7:0] d;

        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_ferr", bus.frame_err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Single good frame
        send(8'h5A, 1'b1);
        hold(1'b1, BIT);
        chk("5A_nvalid", n_valid, 1);
        chk("5A_data", bus.data, 8'h5A);
        chk("5A_dq", dq[0], 8'h5A);
        chk("5A_ferr", n_ferr, 0);
        chk("5A_busy", bus.busy, 1'b0);
        chk("5A_lat", (lat >= LAT - TD) && (lat <= LAT + TD), 1'b1);

        // Back-to-back frames, no idle gap
        nv = n_valid;
        i0 = dq.size();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, BIT);
        chk("b2b_nvalid", n_valid - nv, 2);
        chk("b2b_first", dq[i0], 8'h00);
        chk("b2b_second", dq[i0+1], 8'hFF);
        chk("b2b_data", bus.data, 8'hFF);

        // 20-clk glitch is rejected at mid start bit
        nv = n_valid;
        nf = n_ferr;
        hold(1'b0, 20);
        bus.rx = 1'b1;
        for (int k = 0; k < 60 && bus.busy; k++) begin
            @(negedge clk);
            #1;
        end
        dur = cyc - t_busy;
        chk("glitch_busy", bus.busy, 1'b0);
        chk("glitch_dur", (dur >= 8 * TD - 2) && (dur <= 8 * TD + 2), 1'b1);
        hold(1'b1, BIT);
        chk("glitch_nvalid", n_valid - nv, 0);
        chk("glitch_nferr", n_ferr - nf, 0);
        chk("glitch_data", bus.data, 8'hFF);

        // Bad stop bit followed by a break
        send(8'hA5, 1'b0);
        hold(1'b0, 3 * BIT);
        chk("brk_nferr", n_ferr - nf, 1);
        chk("brk_nvalid", n_valid - nv, 0);
        chk("brk_data", bus.data, 8'hFF);
        chk("brk_busy_hi", bus.busy, 1'b1);
        hold(1'b1, 6);
        chk("brk_busy_lo", bus.busy, 1'b0);
        chk("brk_nferr2", n_ferr - nf, 1);
        hold(1'b1, BIT);

        // Reset in the middle of data bit 4
        d = 8'h3C;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(d[i], BIT);
        hold(d[4], BIT / 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_data", bus.data, 8'h00);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_valid", bus.valid, 1'b0);
        chk("mrst_ferr", bus.frame_err, 1'b0);
        bus.rx = 1'b1;
        rst_n  = 1'b1;
        hold(1'b1, 2 * BIT);
        chk("mrst_nvalid", n_valid - nv, 0);
        chk("mrst_nferr", n_ferr - nf, 1);
        send(8'h3C, 1'b1);
        hold(1'b1, BIT);
        chk("3C_nvalid", n_valid - nv, 1);
        chk("3C_data", bus.data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        nv = n_valid;
        send_p(8'h07, 1'b0, 1'b1);
        hold(1'b1, BIT);
        chk("par_bad_nperr", n_perr, 1);
        chk("par_bad_nvalid", n_valid - nv, 0);
        chk("par_bad_data", bus.data, 8'h3C);
        send_p(8'h07, 1'b1, 1'b1);
        hold(1'b1, BIT);
        chk("par_ok_nperr", n_perr, 1);
        chk("par_ok_nvalid", n_valid - nv, 1);
        chk("par_ok_data", bus.data, 8'h07);
`endif

        chk("no_overlap", n_both, 0);
        chk("pulse_width", n_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter TICK_DIV, default 326, meaning clk cycles per 16x-oversample tick (50 MHz / (9600 x 16), rounded).
REQ-002 Parameter DATA_BITS, default 8, meaning payload bits per frame, LSB first.
REQ-003 Port clk  input  1  meaning system clock (MAX10_CLK1_50 domain), rising edge.
REQ-004 Port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-005 Port rx  input  1  meaning asynchronous serial line, idle high.
REQ-006 Port data  output  DATA_BITS  meaning last received payload.
REQ-007 Port valid  output  1  meaning one-cycle pulse, data holds a new good frame.
REQ-008 Port frame_err  output  1  meaning one-cycle pulse, stop bit sampled low.
REQ-009 Port busy  output  1  meaning high from start-bit detection until return to IDLE.

Function
REQ-010 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 Tick counter shall count 0..TICK_DIV-1 and wrap, emitting one-cycle tick at wrap; it runs freely, except that it clears to 0 on start-bit detection.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE -> START on synchronized rx low; sample counter cleared.
REQ-014 START: on 8th tick, rx high -> IDLE (glitch rejected, no pulse); rx low -> DATA, sample counter cleared.
REQ-015 DATA: each 16th tick samples rx into shift register bit index 0..DATA_BITS-1, LSB first; after last bit -> STOP.
REQ-016 STOP: on 16th tick, rx high -> data updated, valid pulses the next cycle, -> IDLE; rx low -> frame_err pulses the next cycle, data unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH -> IDLE only when synchronized rx high; a break (rx held low) shall produce exactly one frame_err.
REQ-018 valid and frame_err shall never assert in the same cycle; each is exactly one cycle wide.
REQ-019 data shall hold its value between frames.
REQ-020 busy shall be low only in IDLE.
REQ-021 Start-detect-to-valid latency: 2 sync cycles + (1.5 + DATA_BITS) x 16 x TICK_DIV cycles, +/- 1 tick.

Reset
REQ-022 With rst_n low at a clk edge, the state shall be IDLE, counters 0, shift register 0, and data 0; valid, frame_err, and busy shall be 0; synchronizer flops shall be 1.
REQ-023 Reset mid-frame shall abort the frame with no valid or frame_err pulse.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: when defined, a PARITY state shall follow DATA and sample an even-parity bit, and a parity_err output (1 bit, one-cycle pulse with the frame's stop result) shall be added; on mismatch, valid shall be suppressed and data left unchanged.
REQ-025 Without UART_RX_PARITY_EN, there shall be no PARITY state, no parity_err port, and the frame shall be 8N1.

Structure
REQ-026 Package uart_pkg shall hold the FSM state encoding, OVERSAMPLE=16, MID_SAMPLE=8, and default TICK_DIV.
REQ-027 Sub-module uart_baud_tick (counter plus clear input) shall generate tick; the FSM and shift register live in uart_rx.

Verification
REQ-028 The bench shall use TICK_DIV=4, so that 1 bit = 64 clk.
REQ-029 Frame 0x5A with good stop -> one valid pulse, data=0x5A, frame_err=0, busy low after the stop.
REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses, in order, with matching data.
REQ-031 rx low pulse of 20 clk -> no valid, no frame_err, busy returns low at about the 8th tick.
REQ-032 Frame 0xA5 with stop=0, then line low for 3 bit times -> one frame_err, data keeps its prior value, busy stays high until rx goes high.
REQ-033 rst_n low during DATA bit 4 of 0x3C -> outputs 0, no pulse; the next clean frame 0x3C is received correctly.
REQ-034 With UART_RX_PARITY_EN and frame 0x07 with parity bit 0 (wrong) -> parity_err pulse, no valid; with parity bit 1 -> valid, data=0x07.
